// File: rtl/elevator_call_latch_if.sv
// elevator_call_latch_if: raw buttons, floor/serve status and pending-call outputs of the call latch
interface elevator_call_latch_if;
  logic [3:0] car_btn_in;
  logic       up_gnd_in, up_one_in, up_two_in;
  logic       down_one_in, down_two_in, down_three_in;
  logic [1:0] cur_floor;
  logic       serve_valid, serve_dir;
  logic [3:0] car_req;
  logic [2:0] hall_up_req, hall_dn_req;
  logic       any_req;
  logic [1:0] target_floor;
  logic       target_valid;
  logic [1:0] dir_state;
  modport master (
    output car_btn_in, up_gnd_in, up_one_in, up_two_in, down_one_in, down_two_in, down_three_in,
    output cur_floor, serve_valid, serve_dir,
    input  car_req, hall_up_req, hall_dn_req, any_req, target_floor, target_valid, dir_state
  );
  modport slave (
    input  car_btn_in, up_gnd_in, up_one_in, up_two_in, down_one_in, down_two_in, down_three_in,
    input  cur_floor, serve_valid, serve_dir,
    output car_req, hall_up_req, hall_dn_req, any_req, target_floor, target_valid, dir_state
  );
endinterface

// File: rtl/elevator_call_latch.sv
// elevator_call_latch: synchronize/debounce/latch car and hall calls, pick the next SCAN target.
// Define CALL_DEBOUNCE_EN to build the per-input debounce counters.
module elevator_call_latch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  elevator_call_latch_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end

  function automatic logic [1:0] f_lo(input logic [3:0] m);
    f_lo = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction

  function automatic logic [1:0] f_hi(input logic [3:0] m);
    f_hi = m[3] ? 2'd3 : m[2] ? 2'd2 : m[1] ? 2'd1 : 2'd0;
  endfunction

  logic [9:0] w_raw, r_s1, r_s2, w_filt, r_filt_q, w_press;
  logic [3:0] r_car, w_at, w_hit, w_below, w_above, w_up_f, w_dn_f, w_call;
  logic [3:0] w_cu, w_du, w_cd, w_dd;
  logic [2:0] r_up, r_dn;
  logic [1:0] r_dir, w_dir_nx, r_tgt, w_tgt;
  logic       r_tv, w_tv, w_a, w_b;

  assign w_raw = {bus.down_three_in, bus.down_two_in, bus.down_one_in,
                  bus.up_two_in, bus.up_one_in, bus.up_gnd_in, bus.car_btn_in};

  always_ff @(posedge clk)
    if (!rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_filt_q <= '0;
    end else begin
      r_s1     <= w_raw;
      r_s2     <= r_s1;
      r_filt_q <= w_filt;
    end

`ifdef CALL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [9:0]    r_filt;
  logic [CW-1:0] r_cnt [10];

  always_ff @(posedge clk)
    for (int i = 0; i < 10; i++)
      if (!rst) begin
        r_cnt[i]  <= '0;
        r_filt[i] <= 1'b0;
      end else if (r_s2[i] == r_filt[i]) begin
        r_cnt[i] <= '0;
      end else if (r_cnt[i] == LAST) begin
        r_filt[i] <= r_s2[i];
        r_cnt[i]  <= '0;
      end else begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end

  assign w_filt = r_filt;
`else
  assign w_filt = r_s2;
`endif

  assign w_press = w_filt & ~r_filt_q;
  assign w_at    = 4'b0001 << bus.cur_floor;
  assign w_hit   = bus.serve_valid ? w_at : 4'b0000;

  // floor 0 only has an up call and floor 3 only a down call, so those clear on any serve
  always_ff @(posedge clk)
    if (!rst) begin
      r_car <= '0;
      r_up  <= '0;
      r_dn  <= '0;
    end else begin
      r_car <= (r_car | w_press[3:0]) & ~w_hit;
      r_up  <= (r_up | w_press[6:4]) & ~(w_hit[2:0] & {{2{bus.serve_dir}}, 1'b1});
      r_dn  <= (r_dn | w_press[9:7]) & ~(w_hit[3:1] & {1'b1, {2{~bus.serve_dir}}});
    end

  assign w_below = w_at - 4'b0001;
  assign w_above = ~(w_below | w_at);
  assign w_up_f  = {1'b0, r_up};
  assign w_dn_f  = {r_dn, 1'b0};
  assign w_call  = r_car | w_up_f | w_dn_f;
  assign w_a     = |(w_call & w_above);
  assign w_b     = |(w_call & w_below);
  assign w_cu    = (r_car | w_up_f) & w_above;
  assign w_du    = w_dn_f & w_above;
  assign w_cd    = (r_car | w_dn_f) & w_below;
  assign w_dd    = w_up_f & w_below;

  // target follows the direction being entered so both registers move together
  always_comb begin
    w_dir_nx = r_dir == DOWN ? (w_b ? DOWN : w_a ? UP : IDLE) : (w_a ? UP : w_b ? DOWN : IDLE);
    w_tv     = w_dir_nx == UP ? |{w_cu, w_du} : w_dir_nx == DOWN ? |{w_cd, w_dd} : |(w_call & w_at);
    w_tgt    = w_dir_nx == UP ? (|w_cu ? f_lo(w_cu) : f_hi(w_du))
             : w_dir_nx == DOWN ? (|w_cd ? f_hi(w_cd) : f_lo(w_dd)) : bus.cur_floor;
  end

  always_ff @(posedge clk)
    if (!rst) begin
      r_dir <= IDLE;
      r_tgt <= 2'd0;
      r_tv  <= 1'b0;
    end else begin
      r_dir <= w_dir_nx;
      r_tgt <= w_tv ? w_tgt : 2'd0;
      r_tv  <= w_tv;
    end

  assign bus.car_req      = r_car;
  assign bus.hall_up_req  = r_up;
  assign bus.hall_dn_req  = r_dn;
  assign bus.any_req      = |{r_car, r_up, r_dn};
  assign bus.target_floor = r_tgt;
  assign bus.target_valid = r_tv;
  assign bus.dir_state    = r_dir;
endmodule
